// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush controller for the 5-stage MIPS pipeline.
// Optional stall-cycle performance counter enabled by defining HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic [1:0]  TuseRsD,
    input  logic [1:0]  TuseRtD,
    input  logic [4:0]  rsE,
    input  logic [4:0]  rtE,
    input  logic [4:0]  wrE,
    input  logic [4:0]  wrM,
    input  logic [4:0]  wrW,
    input  logic [1:0]  Res_E,
    input  logic [1:0]  Res_M,
    input  logic [1:0]  Res_W,
    input  logic        md_useD,
    input  logic        md_startE,
    input  logic        md_typeE,
    input  logic        exc_M,
    input  logic        eret_M,
    output logic        PC_en,
    output logic        IFID_en,
    output logic        IFID_clr,
    output logic        IDEX_clr,
    output logic        EXMEM_clr,
    output logic        MEMWB_clr,
    output logic [1:0]  fwd_rsD,
    output logic [1:0]  fwd_rtD,
    output logic [1:0]  fwd_rsE,
    output logic [1:0]  fwd_rtE,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    localparam logic [1:0] RES_NW  = 2'b00;
    localparam logic [1:0] RES_ALU = 2'b01;
    localparam logic [1:0] RES_DM  = 2'b10;
    localparam logic [1:0] RES_PC  = 2'b11;

    localparam int MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int MD_W   = $clog2(MD_MAX + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        REDIR = 1'b1
    } flush_state_e;

    // ---------------- Tnew of the producers in E and M ----------------
    logic [1:0] tnew_e;
    logic [1:0] tnew_m;

    always_comb begin
        tnew_e = 2'd0;
        case (Res_E)
            RES_ALU: tnew_e = 2'd1;
            RES_DM:  tnew_e = 2'd2;
            default: tnew_e = 2'd0;
        endcase
        tnew_m = (Res_M == RES_DM) ? 2'd1 : 2'd0;
    end

    function automatic logic src_stall(input logic [4:0] r, input logic [1:0] tuse,
                                       input logic [4:0] wr_e, input logic [1:0] res_e,
                                       input logic [1:0] tn_e, input logic [4:0] wr_m,
                                       input logic [1:0] res_m, input logic [1:0] tn_m);
        logic hit_e;
        logic hit_m;
        hit_e = (r == wr_e) && (res_e != RES_NW) && (tn_e > tuse);
        hit_m = (r == wr_m) && (res_m != RES_NW) && (tn_m > tuse);
        return (r != 5'd0) && (hit_e || hit_m);
    endfunction

    // ALU/PC results are the ones already computed when they sit in M (Res[0] set).
    function automatic logic [1:0] fwd_d_sel(input logic [4:0] r, input logic [4:0] wr_e,
                                             input logic [1:0] res_e, input logic [4:0] wr_m,
                                             input logic [1:0] res_m);
        logic [1:0] sel;
        sel = 2'b00;
        if (r != 5'd0) begin
            if (r == wr_e && res_e == RES_PC)
                sel = 2'b10;
            else if (r == wr_m && (res_m == RES_ALU || res_m == RES_PC))
                sel = 2'b01;
        end
        return sel;
    endfunction

    function automatic logic [1:0] fwd_e_sel(input logic [4:0] r, input logic [4:0] wr_m,
                                             input logic [1:0] res_m, input logic [4:0] wr_w,
                                             input logic [1:0] res_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (r != 5'd0) begin
            if (r == wr_m && (res_m == RES_ALU || res_m == RES_PC))
                sel = 2'b01;
            else if (r == wr_w && res_w != RES_NW)
                sel = 2'b10;
        end
        return sel;
    endfunction

    logic data_stall;
    logic md_stall;
    logic stall;

    assign data_stall = src_stall(rsD, TuseRsD, wrE, Res_E, tnew_e, wrM, Res_M, tnew_m)
                      | src_stall(rtD, TuseRtD, wrE, Res_E, tnew_e, wrM, Res_M, tnew_m);
    assign md_stall   = md_useD & (md_busy | md_startE);
    assign stall      = data_stall | md_stall;

    assign fwd_rsD = fwd_d_sel(rsD, wrE, Res_E, wrM, Res_M);
    assign fwd_rtD = fwd_d_sel(rtD, wrE, Res_E, wrM, Res_M);
    assign fwd_rsE = fwd_e_sel(rsE, wrM, Res_M, wrW, Res_W);
    assign fwd_rtE = fwd_e_sel(rtE, wrM, Res_M, wrW, Res_W);

    // ---------------- Multiply/divide busy counter ----------------
    logic [MD_W-1:0] md_cnt_q;
    logic [MD_W-1:0] md_cnt_d;

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (exc_M)
            md_cnt_d = '0;
        else if (md_startE)
            md_cnt_d = md_typeE ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
        else if (md_cnt_q != '0)
            md_cnt_d = md_cnt_q - MD_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            md_cnt_q <= '0;
        else
            md_cnt_q <= md_cnt_d;
    end

    assign md_busy = (md_cnt_q != '0);

    // ---------------- Post-redirect flush FSM ----------------
    flush_state_e state_q;
    flush_state_e state_d;
    logic         flush_now;
    logic         redir_kill;
    logic         wb_kill;

    always_comb begin
        state_d    = state_q;
        flush_now  = 1'b0;
        redir_kill = 1'b0;
        wb_kill    = 1'b0;
        case (state_q)
            IDLE: begin
                if (exc_M || eret_M) begin
                    flush_now = 1'b1;
                    wb_kill   = exc_M;
                    state_d   = REDIR;
                end
            end
            REDIR: begin
                redir_kill = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    logic redirect;
    assign redirect = flush_now | redir_kill;

    // A redirect must always fetch from the new PC, so it wins over any stall.
    assign PC_en     = ~stall | redirect;
    assign IFID_en   = ~stall | redirect;
    assign IFID_clr  = redirect;
    assign IDEX_clr  = stall | flush_now;
    assign EXMEM_clr = flush_now;
    assign MEMWB_clr = wb_kill;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt_q <= '0;
        else if (stall && !redirect)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Table-driven bench for pipe_hazard_ctrl plus directed multi-cycle sequences
// (load-use, divide busy, exception/eret flush, asynchronous reset).
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rsD, rtD, rsE, rtE, wrE, wrM, wrW;
    logic [1:0]  TuseRsD, TuseRtD, Res_E, Res_M, Res_W;
    logic        md_useD, md_startE, md_typeE, exc_M, eret_M;
    logic        PC_en, IFID_en, IFID_clr, IDEX_clr, EXMEM_clr, MEMWB_clr;
    logic [1:0]  fwd_rsD, fwd_rtD, fwd_rsE, fwd_rtE;
    logic        md_busy;
    logic [31:0] stall_cnt;

`ifdef HAZ_PERF_CNT_EN
    localparam int EXP_MD_STALLS = 11;
`else
    localparam int EXP_MD_STALLS = 0;
`endif

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .TuseRsD(TuseRsD), .TuseRtD(TuseRtD),
        .rsE(rsE), .rtE(rtE), .wrE(wrE), .wrM(wrM), .wrW(wrW),
        .Res_E(Res_E), .Res_M(Res_M), .Res_W(Res_W),
        .md_useD(md_useD), .md_startE(md_startE), .md_typeE(md_typeE),
        .exc_M(exc_M), .eret_M(eret_M),
        .PC_en(PC_en), .IFID_en(IFID_en), .IFID_clr(IFID_clr), .IDEX_clr(IDEX_clr),
        .EXMEM_clr(EXMEM_clr), .MEMWB_clr(MEMWB_clr),
        .fwd_rsD(fwd_rsD), .fwd_rtD(fwd_rtD), .fwd_rsE(fwd_rsE), .fwd_rtE(fwd_rtE),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // {PC_en, IFID_en, IFID_clr, IDEX_clr, EXMEM_clr, MEMWB_clr, fwd_rsD, fwd_rtD, fwd_rsE, fwd_rtE, md_busy}
    logic [14:0] outs;
    assign outs = {PC_en, IFID_en, IFID_clr, IDEX_clr, EXMEM_clr, MEMWB_clr,
                   fwd_rsD, fwd_rtD, fwd_rsE, fwd_rtE, md_busy};

    typedef struct {
        logic [4:0]  rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
        logic [1:0]  tu_rs, tu_rt, res_e, res_m, res_w;
        logic        md_use;
        logic [14:0] exp;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [14:0] mk_exp(input int pc_en, input int idex, input int frsd,
                                           input int frtd, input int frse, input int frte);
        return {1'(pc_en), 1'(pc_en), 1'b0, 1'(idex), 1'b0, 1'b0,
                2'(frsd), 2'(frtd), 2'(frse), 2'(frte), 1'b0};
    endfunction

    function automatic vec_t mkv(input int rsd, input int rtd, input int turs, input int turt,
                                 input int rse, input int rte, input int wre, input int wrm,
                                 input int wrw, input int re, input int rm, input int rw,
                                 input int mdu, input logic [14:0] exp);
        vec_t v;
        v.rs_d = 5'(rsd);  v.rt_d = 5'(rtd);
        v.tu_rs = 2'(turs); v.tu_rt = 2'(turt);
        v.rs_e = 5'(rse);  v.rt_e = 5'(rte);
        v.wr_e = 5'(wre);  v.wr_m = 5'(wrm); v.wr_w = 5'(wrw);
        v.res_e = 2'(re);  v.res_m = 2'(rm); v.res_w = 2'(rw);
        v.md_use = 1'(mdu);
        v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clear_inputs();
        rsD = '0; rtD = '0; rsE = '0; rtE = '0; wrE = '0; wrM = '0; wrW = '0;
        TuseRsD = 2'd3; TuseRtD = 2'd3;
        Res_E = '0; Res_M = '0; Res_W = '0;
        md_useD = 1'b0; md_startE = 1'b0; md_typeE = 1'b0;
        exc_M = 1'b0; eret_M = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        rsD = v.rs_d; rtD = v.rt_d; TuseRsD = v.tu_rs; TuseRtD = v.tu_rt;
        rsE = v.rs_e; rtE = v.rt_e; wrE = v.wr_e; wrM = v.wr_m; wrW = v.wr_w;
        Res_E = v.res_e; Res_M = v.res_m; Res_W = v.res_w;
        md_useD = v.md_use; md_startE = 1'b0; md_typeE = 1'b0;
        exc_M = 1'b0; eret_M = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    localparam logic [14:0] BASE  = 15'b110000_00000000_0;
    localparam logic [14:0] STALL = 15'b000100_00000000_0;

    initial begin
        //         rsD rtD Trs Trt rsE rtE wrE wrM wrW ResE ResM ResW md
        vecs[0]  = mkv(0,  0,  3,  3,  0,  0,  0,  0,  0,  0,  0,  0,  0, mk_exp(1,0,0,0,0,0));
        vecs[1]  = mkv(2,  0,  1,  3,  0,  0,  2,  0,  0,  2,  0,  0,  0, mk_exp(0,1,0,0,0,0));
        vecs[2]  = mkv(2,  0,  0,  3,  0,  0,  0,  2,  0,  0,  2,  0,  0, mk_exp(0,1,0,0,0,0));
        vecs[3]  = mkv(2,  0,  1,  3,  0,  0,  0,  2,  0,  0,  2,  0,  0, mk_exp(1,0,0,0,0,0));
        vecs[4]  = mkv(0,  5,  3,  0,  0,  0,  5,  0,  0,  1,  0,  0,  0, mk_exp(0,1,0,0,0,0));
        vecs[5]  = mkv(0,  5,  3,  1,  0,  0,  5,  0,  0,  1,  0,  0,  0, mk_exp(1,0,0,0,0,0));
        vecs[6]  = mkv(31, 0,  0,  3,  0,  0, 31,  0,  0,  3,  0,  0,  0, mk_exp(1,0,2,0,0,0));
        vecs[7]  = mkv(0,  0,  3,  3,  0,  3,  0,  3,  0,  0,  1,  0,  0, mk_exp(1,0,0,0,0,1));
        vecs[8]  = mkv(0,  0,  3,  3,  0,  3,  0,  0,  0,  0,  1,  0,  0, mk_exp(1,0,0,0,0,0));
        vecs[9]  = mkv(0,  0,  3,  3,  2,  0,  0,  0,  2,  0,  0,  2,  0, mk_exp(1,0,0,0,2,0));
        vecs[10] = mkv(0,  0,  3,  3,  4,  0,  0,  4,  4,  0,  1,  1,  0, mk_exp(1,0,0,0,1,0));
        vecs[11] = mkv(7,  0,  0,  3,  0,  0,  7,  7,  0,  3,  1,  0,  0, mk_exp(1,0,2,0,0,0));
        vecs[12] = mkv(0,  0,  0,  3,  0,  0,  0,  0,  0,  2,  0,  0,  0, mk_exp(1,0,0,0,0,0));
        vecs[13] = mkv(6,  0,  3,  3,  0,  0,  6,  0,  0,  2,  0,  0,  0, mk_exp(1,0,0,0,0,0));
        vecs[14] = mkv(0,  9,  3,  0,  0,  0,  0,  9,  0,  0,  3,  0,  0, mk_exp(1,0,0,1,0,0));
        vecs[15] = mkv(0,  0,  3,  3,  0,  0,  0,  0,  0,  0,  0,  0,  1, mk_exp(1,0,0,0,0,0));
        vecs[16] = mkv(0,  0,  3,  3,  0,  8,  0,  8,  8,  0,  2,  2,  0, mk_exp(1,0,0,0,0,2));
        vecs[17] = mkv(0,  0,  3,  3, 10,  0,  0,  0, 10,  0,  0,  0,  0, mk_exp(1,0,0,0,0,0));

        reset = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", 32'(outs), 32'(BASE));
        check("reset_stall_cnt", stall_cnt, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            next_cycle();
            apply_vec(vecs[i]);
            @(negedge clk);
            check($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
        end

        // load-use: lw $2 in E, add in D needing rs at Tuse=1
        next_cycle(); clear_inputs();
        wrE = 5'd2; Res_E = 2'b10; rsD = 5'd2; TuseRsD = 2'd1;
        @(negedge clk); check("lu_c0_stall", 32'(outs), 32'(STALL));
        next_cycle();
        wrE = 5'd0; Res_E = 2'b00; wrM = 5'd2; Res_M = 2'b10;
        @(negedge clk); check("lu_c1_go", 32'(outs), 32'(BASE));
        next_cycle();
        wrM = 5'd0; Res_M = 2'b00; wrW = 5'd2; Res_W = 2'b10;
        rsD = 5'd0; TuseRsD = 2'd3; rsE = 5'd2;
        @(negedge clk); check("lu_c2_fwd_w", 32'(outs), 32'(mk_exp(1,0,0,0,2,0)));
        next_cycle(); clear_inputs();
        @(negedge clk); check("lu_c3_idle", 32'(outs), 32'(BASE));

        // divide busy window with mfhi waiting in D; counter cleared first
        next_cycle(); reset = 1'b0; #1; reset = 1'b1;
        next_cycle(); clear_inputs();
        md_startE = 1'b1; md_typeE = 1'b1; md_useD = 1'b1;
        @(negedge clk); check("div_start_stall", 32'(outs), 32'(STALL));
        for (int k = 1; k <= 12; k++) begin
            next_cycle();
            md_startE = 1'b0;
            @(negedge clk);
            if (k <= 10)
                check($sformatf("div_busy_c%0d", k), 32'(outs), 32'(STALL | 15'd1));
            else
                check($sformatf("div_done_c%0d", k), 32'(outs), 32'(BASE));
            if (k == 11)
                check("div_stall_cnt", stall_cnt, 32'(EXP_MD_STALLS));
        end

        // exception during mult busy, with a load-use stall present at the same time
        next_cycle(); clear_inputs();
        md_startE = 1'b1; md_typeE = 1'b0;
        next_cycle(); clear_inputs();
        exc_M = 1'b1; wrE = 5'd2; Res_E = 2'b10; rsD = 5'd2; TuseRsD = 2'd1;
        @(negedge clk); check("exc_flush", 32'(outs), 32'(15'b111111_00000000_1));
        next_cycle(); clear_inputs();
        @(negedge clk); check("exc_redir", 32'(outs), 32'(15'b111000_00000000_0));
        next_cycle();
        @(negedge clk); check("exc_idle", 32'(outs), 32'(BASE));

        // eret keeps the W write; a second event during REDIR is ignored
        next_cycle(); eret_M = 1'b1;
        @(negedge clk); check("eret_flush", 32'(outs), 32'(15'b111110_00000000_0));
        next_cycle(); eret_M = 1'b0; exc_M = 1'b1;
        @(negedge clk); check("redir_ignores_exc", 32'(outs), 32'(15'b111000_00000000_0));
        next_cycle(); clear_inputs();
        @(negedge clk); check("eret_idle", 32'(outs), 32'(BASE));

        // asynchronous reset in the middle of a divide stall
        next_cycle(); md_startE = 1'b1; md_typeE = 1'b1; md_useD = 1'b1;
        next_cycle(); md_startE = 1'b0;
        @(negedge clk); check("pre_rst_stall", 32'(outs), 32'(STALL | 15'd1));
        #1 reset = 1'b0;
        #1 check("rst_mid_stall", 32'(outs), 32'(BASE));
        check("rst_mid_stall_cnt", stall_cnt, 32'd0);
        next_cycle(); reset = 1'b1; clear_inputs();

        // asynchronous reset in the middle of REDIR
        next_cycle(); exc_M = 1'b1;
        next_cycle(); exc_M = 1'b0;
        check("pre_rst_redir", 32'(outs), 32'(15'b111000_00000000_0));
        #1 reset = 1'b0;
        #1 check("rst_mid_redir", 32'(outs), 32'(BASE));
        next_cycle(); reset = 1'b1;
        @(negedge clk); check("post_rst_idle", 32'(outs), 32'(BASE));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
